sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, SRAM strobe-low width in clk cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; every register is clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 P0_REQ / P1_REQ  input  1 each  access request from port 0 / port 1.
REQ-005 P0_WE / P1_WE  input  1 each  1 = write, 0 = read.
REQ-006 P0_A / P1_A  input  19 each  byte address.
REQ-007 P0_WD / P1_WD  input  8 each  write data.
REQ-008 P0_ACK / P1_ACK  output  1 each  one-cycle completion pulse.
REQ-009 P0_RD / P1_RD  output  8 each  read data.
REQ-010 SRAM_D  inout  8  SRAM data bus; hi-z unless this block is writing.
REQ-011 SRAM_A  output  19  SRAM address.
REQ-012 SRAM_nCS / SRAM_nOE / SRAM_nWE  output  1 each  active-low SRAM strobes.

Function
REQ-013 States: IDLE, SETUP, ACCESS, HOLD. Transitions: IDLE->SETUP on any request; SETUP->ACCESS always; ACCESS->HOLD after WAIT_CYCLES cycles; HOLD->IDLE always.
REQ-014 Requests are sampled only in IDLE; requests in any other state are ignored until IDLE returns.
REQ-015 Arbitration is round-robin on a last-grant bit:
- Only one port requesting: that port is granted.
- Both requesting: the port not granted last time is granted.
REQ-016 On grant, the granted port's WE, A and WD are captured; the transaction uses only the captured values.
REQ-017 Each registered output is driven from the current state, so outputs change at clock edges only:
- SRAM_A: captured address from SETUP through HOLD.
- SRAM_nCS: low in SETUP and ACCESS only.
- SRAM_nOE: low in ACCESS for reads only.
- SRAM_nWE: low in ACCESS for writes only.
REQ-018 Write data is driven on SRAM_D from SETUP through HOLD inclusive, giving 1 cycle of setup and 1 cycle of hold around nWE.
REQ-019 Read data is sampled from SRAM_D at the clock edge that ends the last ACCESS cycle, while nOE is still low.
REQ-020 The granted port's ACK is high for exactly the HOLD cycle.
REQ-021 On a read, that port's RD is valid in the HOLD cycle and holds its value until that port's next read completes.
REQ-022 A write leaves RD unchanged.
REQ-023 Latency: with the request sampled at edge E0, ACK is high from E0+1+WAIT_CYCLES to E0+2+WAIT_CYCLES. Total occupancy is WAIT_CYCLES+3 cycles per access.
REQ-024 Requester rule: hold REQ and its fields until ACK is seen, then deassert REQ at the edge ending HOLD. A REQ still high in the following IDLE is treated as a new request.
REQ-025 SRAM_nOE and SRAM_nWE are never low in the same cycle.
REQ-026 SRAM_D is never driven while SRAM_nOE is low.
REQ-027 Back-to-back requests: IDLE lasts exactly one cycle between transactions, so no strobe overlap can occur.

Reset
REQ-028 While reset is high, asynchronously and independent of clk:
- State is IDLE.
- SRAM_nCS, SRAM_nOE and SRAM_nWE are high.
- SRAM_D is hi-z.
- SRAM_A, P0_RD and P1_RD are 0.
- Both ACKs are low.
- Last-grant points to port 1, so port 0 wins the first tie.
REQ-029 Reset asserted mid-transaction aborts it immediately: no ACK is issued, and strobes go inactive without waiting for a clock.
REQ-030 After reset deasserts, the first request is sampled at the first rising edge of clk.

Verification
REQ-031 The bench SHALL use WAIT_CYCLES=2 and SRAM model content mem[0x00010]=0x5A, and cover the following scenarios:
- P0 read 0x00010 with the request at edge 0 -> nCS low cycles 1-3, nOE low cycles 2-3, P0_ACK high in cycle 4, P0_RD=0x5A.
- P1 write 0x7FFFF=0xC3 -> nWE low for 2 cycles; SRAM_D=0xC3 from SETUP through HOLD; a subsequent read of 0x7FFFF returns 0xC3.
- P0 and P1 requesting simultaneously and continuously after reset -> grants alternate P0, P1, P0, P1; each transaction takes 5 cycles with a single IDLE cycle between them.
- Reset asserted during ACCESS of a write -> nWE and nCS high and SRAM_D hi-z within the same cycle; no ACK; memory content unchanged.
- Write followed by a read on P0 -> P0_RD keeps its prior value through the write and updates only on the read ACK.
- Throughout every scenario -> SRAM_nOE and SRAM_nWE are never low together, and SRAM_D is never driven while nOE is low.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of an asynchronous
// 8-bit SRAM. Each access walks IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD
// with all SRAM strobes, the data-bus enable and the port ACK/RD outputs
// registered. The registered outputs are computed from the next state, so
// they line up with the state and change only at clock edges.
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        P0_REQ,
   input  logic        P0_WE,
   input  logic [18:0] P0_A,
   input  logic [7:0]  P0_WD,
   output logic        P0_ACK,
   output logic [7:0]  P0_RD,
   input  logic        P1_REQ,
   input  logic        P1_WE,
   input  logic [18:0] P1_A,
   input  logic [7:0]  P1_WD,
   output logic        P1_ACK,
   output logic [7:0]  P1_RD,
   inout  wire  [7:0]  SRAM_D,
   output logic [18:0] SRAM_A,
   output logic        SRAM_nCS,
   output logic        SRAM_nOE,
   output logic        SRAM_nWE
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] HOLD   = 2'd3;

   // Counter value on the last ACCESS cycle.
   localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

   logic [1:0]  state_r;
   logic [1:0]  nextState_s;
   logic [3:0]  waitCnt_r;
   logic        grant_r;
   logic        lastGrant_r;
   logic        anyReq_s;
   logic        grantSel_s;
   logic        selWe_s;
   logic [18:0] selA_s;
   logic [7:0]  selWd_s;
   logic        captWe_r;
   logic [18:0] captA_r;
   logic [7:0]  captWd_r;
   logic        txnWe_s;
   logic [18:0] txnA_s;
   logic        driveEn_r;
   logic        readDone_s;

   // The data bus is released whenever this block is not writing.
   assign SRAM_D = driveEn_r ? captWd_r : 8'bzzzz_zzzz;

   // Round-robin pick between the ports and mux of the winner's fields.
   always_comb begin
      anyReq_s = P0_REQ | P1_REQ;
      if (P0_REQ && P1_REQ) begin
         grantSel_s = ~lastGrant_r;
      end else if (P1_REQ) begin
         grantSel_s = 1'b1;
      end else begin
         grantSel_s = 1'b0;
      end
      if (grantSel_s) begin
         selWe_s = P1_WE;
         selA_s  = P1_A;
         selWd_s = P1_WD;
      end else begin
         selWe_s = P0_WE;
         selA_s  = P0_A;
         selWd_s = P0_WD;
      end
   end

   // Transaction fields: live winner while granting in IDLE, captured copy afterwards.
   always_comb begin
      if (state_r == IDLE) begin
         txnWe_s = selWe_s;
         txnA_s  = selA_s;
      end else begin
         txnWe_s = captWe_r;
         txnA_s  = captA_r;
      end
   end

   // Next-state decode; requests are only looked at in IDLE.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (anyReq_s) begin
               nextState_s = SETUP;
            end else begin
               nextState_s = IDLE;
            end
         end
         SETUP: nextState_s = ACCESS;
         ACCESS: begin
            if (waitCnt_r == LAST_WAIT) begin
               nextState_s = HOLD;
            end else begin
               nextState_s = ACCESS;
            end
         end
         HOLD: nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
      readDone_s = (state_r == ACCESS) && (nextState_s == HOLD) && !captWe_r;
   end

   // State, access-length counter, grant bookkeeping and request capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         waitCnt_r   <= 4'd0;
         grant_r     <= 1'b0;
         lastGrant_r <= 1'b1;
         captWe_r    <= 1'b0;
         captA_r     <= 19'd0;
         captWd_r    <= 8'd0;
      end else begin
         state_r <= nextState_s;
         if (state_r == ACCESS) begin
            waitCnt_r <= waitCnt_r + 4'd1;
         end else begin
            waitCnt_r <= 4'd0;
         end
         if ((state_r == IDLE) && anyReq_s) begin
            grant_r     <= grantSel_s;
            lastGrant_r <= grantSel_s;
            captWe_r    <= selWe_s;
            captA_r     <= selA_s;
            captWd_r    <= selWd_s;
         end else begin
            grant_r     <= grant_r;
            lastGrant_r <= lastGrant_r;
            captWe_r    <= captWe_r;
            captA_r     <= captA_r;
            captWd_r    <= captWd_r;
         end
      end
   end

   // Registered SRAM strobes, address, bus enable and ACK pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         SRAM_A    <= 19'd0;
         SRAM_nCS  <= 1'b1;
         SRAM_nOE  <= 1'b1;
         SRAM_nWE  <= 1'b1;
         driveEn_r <= 1'b0;
         P0_ACK    <= 1'b0;
         P1_ACK    <= 1'b0;
      end else begin
         if (nextState_s == IDLE) begin
            SRAM_A <= 19'd0;
         end else begin
            SRAM_A <= txnA_s;
         end
         SRAM_nCS  <= ~((nextState_s == SETUP) | (nextState_s == ACCESS));
         SRAM_nOE  <= ~((nextState_s == ACCESS) & ~txnWe_s);
         SRAM_nWE  <= ~((nextState_s == ACCESS) & txnWe_s);
         driveEn_r <= (nextState_s != IDLE) & txnWe_s;
         P0_ACK    <= (nextState_s == HOLD) & ~grant_r;
         P1_ACK    <= (nextState_s == HOLD) & grant_r;
      end
   end

   // Read data is taken on the edge that ends ACCESS, while nOE is still low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         P0_RD <= 8'd0;
         P1_RD <= 8'd0;
      end else if (readDone_s) begin
         if (grant_r) begin
            P1_RD <= SRAM_D;
         end else begin
            P0_RD <= SRAM_D;
         end
      end else begin
         P0_RD <= P0_RD;
         P1_RD <= P1_RD;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed accesses against a behavioural async SRAM.
// Stimulus pushes the expected ACK/RD per transaction into a queue; a monitor
// pops and compares on every ACK and also watches bus-protocol invariants.
module tb_sram_arbiter;

   logic        clk;
   logic        reset;
   logic        P0_REQ, P0_WE, P1_REQ, P1_WE;
   logic [18:0] P0_A, P1_A;
   logic [7:0]  P0_WD, P1_WD;
   logic        P0_ACK, P1_ACK;
   logic [7:0]  P0_RD, P1_RD;
   wire  [7:0]  SRAM_D;
   logic [18:0] SRAM_A;
   logic        SRAM_nCS, SRAM_nOE, SRAM_nWE;

   int errCnt = 0;
   int chkCnt = 0;

   typedef struct {
      logic       port;
      logic [7:0] rd;
   } expItem_t;

   expItem_t   sbQ[$];
   logic [7:0] expRd [0:1];
   logic [7:0] mem [0:524287];

   sram_arbiter #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_A(P0_A), .P0_WD(P0_WD),
      .P0_ACK(P0_ACK), .P0_RD(P0_RD),
      .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_A(P1_A), .P1_WD(P1_WD),
      .P1_ACK(P1_ACK), .P1_RD(P1_RD),
      .SRAM_D(SRAM_D), .SRAM_A(SRAM_A),
      .SRAM_nCS(SRAM_nCS), .SRAM_nOE(SRAM_nOE), .SRAM_nWE(SRAM_nWE)
   );

   // SRAM model: drives the bus while selected and output-enabled.
   assign SRAM_D = (!SRAM_nCS && !SRAM_nOE) ? mem[SRAM_A] : 8'bzzzz_zzzz;

   // SRAM model: a write commits on the rising edge of nWE; a pulse cut short by reset is discarded.
   always @(posedge SRAM_nWE) begin
      if (!reset) mem[SRAM_A] = SRAM_D;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
      end
   endtask

   task automatic pushExp(input logic port, input logic we, input logic [7:0] data);
      expItem_t it;
      if (!we) expRd[port] = data;
      it.port = port;
      it.rd   = expRd[port];
      sbQ.push_back(it);
   endtask

   // Scoreboard monitor and protocol invariants, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         check("strobeOverlap", {31'd0, (!SRAM_nOE && !SRAM_nWE)}, 32'd0);
         if (!SRAM_nOE) check("readBus", {24'd0, SRAM_D}, {24'd0, mem[SRAM_A]});
         if (P0_ACK || P1_ACK) begin
            check("singleAck", {31'd0, (P0_ACK && P1_ACK)}, 32'd0);
            if (sbQ.size() == 0) begin
               chkCnt++;
               errCnt++;
               $display("FAIL unexpectedAck: got P0_ACK=%0d P1_ACK=%0d, wanted none", P0_ACK, P1_ACK);
            end else begin
               expItem_t it;
               it = sbQ.pop_front();
               check("ackPort", {31'd0, P1_ACK}, {31'd0, it.port});
               check("ackRd", {24'd0, (P1_ACK ? P1_RD : P0_RD)}, {24'd0, it.rd});
            end
         end
      end
   end

   // One access on one port; records per-cycle strobe traces (bit n = n-th falling edge).
   task automatic access(input logic port, input logic we, input logic [18:0] addr,
                         input logic [7:0] wd, output logic [7:0] lowCs, output logic [7:0] lowOe,
                         output logic [7:0] lowWe, output logic [7:0] dMatch,
                         output int ackN, output logic rdStable);
      logic [7:0] prevRd;
      prevRd   = port ? P1_RD : P0_RD;
      lowCs    = 8'd0; lowOe = 8'd0; lowWe = 8'd0; dMatch = 8'd0;
      ackN     = -1;
      rdStable = 1'b1;
      @(posedge clk); #1;
      if (port) begin
         P1_REQ = 1'b1; P1_WE = we; P1_A = addr; P1_WD = wd;
      end else begin
         P0_REQ = 1'b1; P0_WE = we; P0_A = addr; P0_WD = wd;
      end
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         lowCs[n]  = !SRAM_nCS;
         lowOe[n]  = !SRAM_nOE;
         lowWe[n]  = !SRAM_nWE;
         dMatch[n] = (SRAM_D === wd);
         if (port ? P1_ACK : P0_ACK) begin
            ackN = n;
            break;
         end
         if ((port ? P1_RD : P0_RD) !== prevRd) rdStable = 1'b0;
      end
      P0_REQ = 1'b0;
      P1_REQ = 1'b0;
   endtask

   logic [7:0] tCs, tOe, tWe, tD;
   int         tAck;
   logic       tStable;
   int         ackCyc [0:3];
   logic       ackPort [0:3];
   int         ackK;

   initial begin
      reset = 1'b1;
      P0_REQ = 1'b0; P0_WE = 1'b0; P0_A = 19'd0; P0_WD = 8'd0;
      P1_REQ = 1'b0; P1_WE = 1'b0; P1_A = 19'd0; P1_WD = 8'd0;
      expRd[0] = 8'd0; expRd[1] = 8'd0;
      for (int i = 0; i < 524288; i++) mem[i] = 8'h00;
      mem[19'h00010] = 8'h5A;
      mem[19'h00030] = 8'h11;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rstNcs", {31'd0, SRAM_nCS}, 32'd1);
      check("rstNoe", {31'd0, SRAM_nOE}, 32'd1);
      check("rstNwe", {31'd0, SRAM_nWE}, 32'd1);
      check("rstAddr", {13'd0, SRAM_A}, 32'd0);
      check("rstRd", {16'd0, P0_RD, P1_RD}, 32'd0);
      check("rstAck", {30'd0, P0_ACK, P1_ACK}, 32'd0);
      reset = 1'b0;

      // P0 read of 0x00010 (write-data port holds the complement to expose bus contention).
      pushExp(1'b0, 1'b0, 8'h5A);
      access(1'b0, 1'b0, 19'h00010, 8'hA5, tCs, tOe, tWe, tD, tAck, tStable);
      check("rdAckCycle", tAck, 32'd4);
      check("rdNcsTrace", {24'd0, tCs}, 32'h0E);
      check("rdNoeTrace", {24'd0, tOe}, 32'h0C);
      check("rdNweTrace", {24'd0, tWe}, 32'h00);

      // P1 write 0x7FFFF = 0xC3, then read it back.
      pushExp(1'b1, 1'b1, 8'h00);
      access(1'b1, 1'b1, 19'h7FFFF, 8'hC3, tCs, tOe, tWe, tD, tAck, tStable);
      check("wrAckCycle", tAck, 32'd4);
      check("wrNcsTrace", {24'd0, tCs}, 32'h0E);
      check("wrNweTrace", {24'd0, tWe}, 32'h0C);
      check("wrNoeTrace", {24'd0, tOe}, 32'h00);
      check("wrDataTrace", {24'd0, tD}, 32'h1E);
      check("wrMem", {24'd0, mem[19'h7FFFF]}, 32'hC3);
      pushExp(1'b1, 1'b0, 8'hC3);
      access(1'b1, 1'b0, 19'h7FFFF, 8'h3C, tCs, tOe, tWe, tD, tAck, tStable);
      check("rbAckCycle", tAck, 32'd4);

      // P0 write then read: RD keeps 0x5A until the read completes.
      pushExp(1'b0, 1'b1, 8'h00);
      access(1'b0, 1'b1, 19'h00020, 8'h3C, tCs, tOe, tWe, tD, tAck, tStable);
      check("wrRdStable", {31'd0, tStable}, 32'd1);
      check("wrRdKept", {24'd0, P0_RD}, 32'h5A);
      pushExp(1'b0, 1'b0, 8'h3C);
      access(1'b0, 1'b0, 19'h00020, 8'hC3, tCs, tOe, tWe, tD, tAck, tStable);
      check("rdBeforeAck", {31'd0, tStable}, 32'd1);
      check("rdAfterAck", {24'd0, P0_RD}, 32'h3C);

      // Reset during ACCESS of a write to 0x00030.
      @(posedge clk); #1;
      P0_REQ = 1'b1; P0_WE = 1'b1; P0_A = 19'h00030; P0_WD = 8'hEE;
      repeat (3) @(negedge clk);
      check("abortNweLow", {31'd0, SRAM_nWE}, 32'd0);
      #1 reset = 1'b1;
      #1;
      check("abortNwe", {31'd0, SRAM_nWE}, 32'd1);
      check("abortNcs", {31'd0, SRAM_nCS}, 32'd1);
      check("abortBusFree", {31'd0, (SRAM_D !== 8'hEE)}, 32'd1);
      check("abortAck", {30'd0, P0_ACK, P1_ACK}, 32'd0);
      P0_REQ = 1'b0;
      expRd[0] = 8'd0; expRd[1] = 8'd0;
      repeat (2) @(negedge clk);
      check("abortMem", {24'd0, mem[19'h00030]}, 32'h11);

      // Both ports requesting continuously from reset release: P0, P1, P0, P1.
      P0_REQ = 1'b1; P0_WE = 1'b0; P0_A = 19'h00010; P0_WD = 8'hA5;
      P1_REQ = 1'b1; P1_WE = 1'b0; P1_A = 19'h7FFFF; P1_WD = 8'h3C;
      pushExp(1'b0, 1'b0, 8'h5A);
      pushExp(1'b1, 1'b0, 8'hC3);
      pushExp(1'b0, 1'b0, 8'h5A);
      pushExp(1'b1, 1'b0, 8'hC3);
      reset = 1'b0;
      ackK = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if ((P0_ACK || P1_ACK) && ackK < 4) begin
            ackCyc[ackK]  = n;
            ackPort[ackK] = P1_ACK;
            ackK++;
            if (ackK == 4) begin
               P0_REQ = 1'b0;
               P1_REQ = 1'b0;
            end
         end
      end
      P0_REQ = 1'b0;
      P1_REQ = 1'b0;
      check("rrAckCount", ackK, 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < ackK) begin
            check("rrAckCycle", ackCyc[k], 32'(4 + 5 * k));
            check("rrPort", {31'd0, ackPort[k]}, {31'd0, k[0]});
         end
      end

      repeat (3) @(negedge clk);
      check("sbEmpty", sbQ.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, wanted completion");
      $fatal(1, "watchdog expired");
   end

endmodule
